// File: rtl/sbio_pkg.sv
// sbio link shared definitions: header codes, start-bit constants, the tx
// framing state type and width helpers used by the tx arbiter and monitor.
package sbio_pkg;

  // Header codes identifying which producer a frame came from
  localparam int TX_SOURCE_SCAN = 0;
  localparam int TX_SOURCE_READ = 1;
  localparam int TX_SOURCE_OUT  = 2;

  // Pin values for the start cycle and for an idle link
  localparam int SBIO_START_BITS = 1;
  localparam int SBIO_IDLE_BITS  = 0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    HEADER,
    PAYLOAD
  } sbio_tx_state_e;

  function automatic int sbio_word_size(int io_bits, int payload_cycles);
    return io_bits * payload_cycles;
  endfunction

  // Width of a counter/index covering 0..n-1, never narrower than one bit
  function automatic int sbio_cnt_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sbio_monitor.sv
// Passive framing observer for an sbio pin bus. Reports the position of the
// current cycle within a frame (0 idle, 1 start, 2 header, 3.. payload) and a
// sticky error if a frame opens with anything other than the start pattern.
module sbio_monitor
  import sbio_pkg::*;
#(
  parameter int SENS_BITS      = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int START_BITS     = SBIO_START_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [SENS_BITS-1:0]                  pins_i,
  output logic [sbio_cnt_w(PAYLOAD_CYCLES+3)-1:0] pos_o,
  output logic                                  err_o
);

  localparam int PW = sbio_cnt_w(PAYLOAD_CYCLES + 3);
  localparam logic [PW-1:0] LAST = PW'(PAYLOAD_CYCLES + 2);

  logic [PW-1:0] pos_q, pos_d;
  logic          err_q, err_d;

  // A nonzero value outside a frame opens a new one; inside, just count
  always_comb begin
    pos_d = '0;
    if (pos_q == '0 || pos_q == LAST) begin
      if (pins_i != '0) pos_d = PW'(1);
    end else begin
      pos_d = pos_q + PW'(1);
    end
    err_d = err_q | ((pos_d == PW'(1)) && (pins_i != SENS_BITS'(START_BITS)));
  end

  // Position and error history
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      err_q <= err_d;
    end
  end

  assign pos_o = pos_d;
  assign err_o = err_q;

endmodule

// File: rtl/sbio_prio_arbiter.sv
// One-hot grant selection among eligible sources.
// Default: fixed priority, lowest index wins.
// SBIO_TX_RR_ARB_EN: round-robin, search starts just after last_i.
module sbio_prio_arbiter
  import sbio_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]               elig_i,
`ifdef SBIO_TX_RR_ARB_EN
  input  logic [sbio_cnt_w(N)-1:0]   last_i,
`endif
  output logic [N-1:0]               grant_o
);

`ifdef SBIO_TX_RR_ARB_EN
  // Pick the eligible source with the smallest rotational distance after last_i
  always_comb begin
    int best;
    int d;
    grant_o = '0;
    best    = N;
    d       = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(last_i) - 1) % N;
      if (elig_i[i] && d < best) begin
        best    = d;
        grant_o = N'(1) << i;
      end
    end
  end
`else
  // Scan from the top down so the lowest eligible index is the last written
  always_comb begin
    grant_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig_i[i]) grant_o = N'(1) << i;
    end
  end
`endif

endmodule

// File: rtl/sbio_tx_arbiter.sv
// Multi-source sbio transmitter. Grants one producer word at a time and frames
// it on tx_pins as start, header (source id), then payload LSB-first. Tracks
// unanswered transactions and holds off response-expecting sources at the
// limit. Build option SBIO_TX_RR_ARB_EN selects round-robin arbitration.
module sbio_tx_arbiter
  import sbio_pkg::*;
#(
  parameter int                     IO_BITS         = 2,
  parameter int                     PAYLOAD_CYCLES  = 8,
  parameter int                     NUM_SOURCES     = 3,
  parameter int                     START_BITS      = SBIO_START_BITS,
  parameter logic [NUM_SOURCES-1:0] RESPONSE_MASK   = 3'b100,
  parameter int                     MAX_OUTSTANDING = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_SOURCES-1:0]                        src_valid,
  input  logic [NUM_SOURCES*PAYLOAD_CYCLES*IO_BITS-1:0] src_data,
  output logic [NUM_SOURCES-1:0]                        src_ready,
  input  logic                                          rsp_done,
  output logic [IO_BITS-1:0]                            tx_pins,
  output logic                                          busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]          outstanding,
  output logic                                          credit_err
);

  localparam int WS = sbio_word_size(IO_BITS, PAYLOAD_CYCLES);
  localparam int CW = sbio_cnt_w(PAYLOAD_CYCLES);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAYLOAD_CYCLES - 1);

  sbio_tx_state_e       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WS-1:0]        shift_q, shift_d;
  logic [IO_BITS-1:0]   id_q, id_d;
  logic [IO_BITS-1:0]   tx_q, tx_d;
  logic [OW-1:0]        out_q, out_d;
  logic                 cerr_q, cerr_d;

  logic [NUM_SOURCES-1:0] elig, arb_grant, grant_v;
  logic                   grant_win, any_grant, resp_grant, out_full;
  logic [WS-1:0]          gword;
  logic [IO_BITS-1:0]     gid;

  assign out_full = (out_q == OW'(MAX_OUTSTANDING));

  // Response-expecting sources sit out while the credit pool is exhausted
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      elig[i] = src_valid[i] && !(RESPONSE_MASK[i] && out_full);
    end
  end

`ifdef SBIO_TX_RR_ARB_EN
  localparam int PTRW = sbio_cnt_w(NUM_SOURCES);
  logic [PTRW-1:0] ptr_q, ptr_d;

  // Remember the most recent winner as the round-robin origin
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_v[i]) ptr_d = PTRW'(i);
    end
  end

  // Pointer starts at the top so source 0 is searched first
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= PTRW'(NUM_SOURCES - 1);
    else       ptr_q <= ptr_d;
  end

  sbio_prio_arbiter #(.N(NUM_SOURCES)) u_arb (
    .elig_i  (elig),
    .last_i  (ptr_q),
    .grant_o (arb_grant)
  );
`else
  sbio_prio_arbiter #(.N(NUM_SOURCES)) u_arb (
    .elig_i  (elig),
    .grant_o (arb_grant)
  );
`endif

  // Grants only when the link can take a new frame next cycle; never in reset
  assign grant_win  = (state_q == IDLE) || (state_q == PAYLOAD && cnt_q == CNT_LAST);
  assign grant_v    = arb_grant & {NUM_SOURCES{grant_win && !reset}};
  assign any_grant  = |grant_v;
  assign resp_grant = |(grant_v & RESPONSE_MASK);

  // Mux the granted word and its id for capture
  always_comb begin
    gword = '0;
    gid   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_v[i]) begin
        gword = src_data[i*WS +: WS];
        gid   = IO_BITS'(i);
      end
    end
  end

  // Framing FSM; tx_d is what the pins show in the following cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    id_d    = id_q;
    tx_d    = '0;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          state_d = START;
          shift_d = gword;
          id_d    = gid;
          tx_d    = IO_BITS'(START_BITS);
        end
      end
      START: begin
        state_d = HEADER;
        tx_d    = id_q;
      end
      HEADER: begin
        state_d = PAYLOAD;
        cnt_d   = '0;
        tx_d    = shift_q[IO_BITS-1:0];
        shift_d = shift_q >> IO_BITS;
      end
      PAYLOAD: begin
        if (cnt_q == CNT_LAST) begin
          // Chain straight into the next frame when someone is waiting
          if (any_grant) begin
            state_d = START;
            shift_d = gword;
            id_d    = gid;
            tx_d    = IO_BITS'(START_BITS);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          tx_d    = shift_q[IO_BITS-1:0];
          shift_d = shift_q >> IO_BITS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit accounting; a grant and a response in one cycle cancel out
  always_comb begin
    out_d  = out_q;
    cerr_d = cerr_q;
    if (rsp_done && out_q == '0) cerr_d = 1'b1;
    if (resp_grant && !rsp_done) begin
      out_d = out_q + OW'(1);
    end else if (!resp_grant && rsp_done && out_q != '0) begin
      out_d = out_q - OW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      id_q    <= '0;
      tx_q    <= '0;
      out_q   <= '0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      id_q    <= id_d;
      tx_q    <= tx_d;
      out_q   <= out_d;
      cerr_q  <= cerr_d;
    end
  end

  assign src_ready   = grant_v;
  assign tx_pins     = tx_q;
  assign busy        = (state_q != IDLE);
  assign outstanding = out_q;
  assign credit_err  = cerr_q;

  localparam int PW = sbio_cnt_w(PAYLOAD_CYCLES + 3);
  logic [PW-1:0] mon_pos;
  logic          mon_err;

  sbio_monitor #(
    .SENS_BITS      (IO_BITS),
    .PAYLOAD_CYCLES (PAYLOAD_CYCLES),
    .START_BITS     (START_BITS)
  ) u_mon (
    .clk    (clk),
    .reset  (reset),
    .pins_i (tx_q),
    .pos_o  (mon_pos),
    .err_o  (mon_err)
  );

`ifndef SYNTHESIS
  logic [PW-1:0] fsm_pos;

  // Frame position implied by the FSM, in the monitor's numbering
  always_comb begin
    fsm_pos = '0;
    case (state_q)
      START:   fsm_pos = PW'(1);
      HEADER:  fsm_pos = PW'(2);
      PAYLOAD: fsm_pos = PW'(3) + PW'(cnt_q);
      default: fsm_pos = '0;
    endcase
  end

  // Pins observed by the monitor must line up with the FSM every cycle
  always @(posedge clk) begin
    if (!reset) begin
      assert (mon_pos == fsm_pos)
        else $error("sbio_tx_arbiter: monitor pos %0d vs fsm pos %0d", mon_pos, fsm_pos);
      assert (!mon_err)
        else $error("sbio_tx_arbiter: monitor saw a bad start pattern");
    end
  end
`endif

endmodule

// File: tb/tb_sbio_tx_arbiter.sv
// Directed and randomized checks for sbio_tx_arbiter at default parameters.
module tb_sbio_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_valid;
  logic [47:0] src_data;
  logic [2:0]  src_ready;
  logic        rsp_done;
  logic [1:0]  tx_pins;
  logic        busy;
  logic [1:0]  outstanding;
  logic        credit_err;

  int checks = 0;
  int errs   = 0;

  sbio_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .rsp_done    (rsp_done),
    .tx_pins     (tx_pins),
    .busy        (busy),
    .outstanding (outstanding),
    .credit_err  (credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs sampled 3ns after the edge
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  // Called at the start cycle; leaves the bench at the last payload cycle
  task automatic frame_chk(input string tag, input int id, input logic [15:0] word);
    chk({tag, "_st"}, tx_pins, 1);
    chk({tag, "_busy"}, busy, 1);
    adv(); smp();
    chk({tag, "_hdr"}, tx_pins, id);
    for (int k = 0; k < 8; k++) begin
      adv(); smp();
      chk({tag, "_pl"}, tx_pins, (word >> (2 * k)) & 16'h3);
    end
  endtask

  // Independent frame decoder for the random phase
  int          dpos = 0;
  logic [1:0]  dhdr;
  logic [15:0] dword;
  logic [17:0] expq[$];

  task automatic dec_step();
    if (dpos == 0) begin
      if (tx_pins != 2'd0) begin
        chk("rnd_start", tx_pins, 1);
        dpos = 1;
      end
    end else if (dpos == 1) begin
      dhdr  = tx_pins;
      dword = '0;
      dpos  = 2;
    end else begin
      dword[2*(dpos-2) +: 2] = tx_pins;
      dpos++;
      if (dpos == 10) begin
        if (expq.size() == 0) chk("rnd_q_empty", {dhdr, dword}, 32'hFFFF_FFFF);
        else chk("rnd_word", {dhdr, dword}, expq.pop_front());
        dpos = 0;
      end
    end
  endtask

  int          model_out;
  logic [2:0]  rdy;
  logic [2:0]  bad;
  int          exp1[9] = '{1, 3, 0, 0, 3, 1, 1, 2, 2};

  initial begin
    reset = 1'b1; src_valid = '0; src_data = '0; rsp_done = 1'b0;
    adv(); adv(); smp();
    chk("rst_tx", tx_pins, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", src_ready, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_cerr", credit_err, 0);
    adv(); reset = 1'b0; smp();
    chk("idle_tx", tx_pins, 0);

    // Single send from source 1
    adv(); src_valid = 3'b010; src_data[31:16] = 16'hA5C3; smp();
    chk("t1_rdy", src_ready, 3'b010);
    adv(); src_valid = 3'b000; src_data[31:16] = 16'hFFFF; smp();
    chk("t1_st", tx_pins, 1);
    chk("t1_busy0", busy, 1);
    chk("t1_rdy0", src_ready, 0);
    for (int k = 0; k < 9; k++) begin
      adv(); smp();
      chk("t1_pin", tx_pins, exp1[k]);
      chk("t1_busy", busy, 1);
    end
    adv(); smp();
    chk("t1_end_tx", tx_pins, 0);
    chk("t1_end_busy", busy, 0);
    chk("t1_out", outstanding, 0);

    // Contention: source 0 first, source 1 chained with no gap
    adv(); src_valid = 3'b011; src_data[15:0] = 16'h1234; src_data[31:16] = 16'h00FF; smp();
    chk("t2_rdy0", src_ready, 3'b001);
    adv(); src_valid = 3'b010; smp();
    chk("t2_hold", src_ready, 0);
    frame_chk("t2a", 0, 16'h1234);
    chk("t2_rdy1", src_ready, 3'b010);
    adv(); src_valid = 3'b000; smp();
    frame_chk("t2b", 1, 16'h00FF);
    chk("t2_rdy_last", src_ready, 0);
    adv(); smp();
    chk("t2_end_tx", tx_pins, 0);
    chk("t2_end_busy", busy, 0);

    // Credit limit on source 2
    adv(); src_valid = 3'b100; src_data[47:32] = 16'hBEEF; smp();
    chk("t3_rdy_a", src_ready, 3'b100);
    adv(); smp();
    chk("t3_out1", outstanding, 1);
    frame_chk("t3a", 2, 16'hBEEF);
    chk("t3_rdy_b", src_ready, 3'b100);
    adv(); smp();
    chk("t3_out2", outstanding, 2);
    frame_chk("t3b", 2, 16'hBEEF);
    chk("t3_blk_last", src_ready, 0);
    adv(); smp();
    chk("t3_idle_tx", tx_pins, 0);
    chk("t3_idle_busy", busy, 0);
    chk("t3_blk_idle", src_ready, 0);
    chk("t3_out2b", outstanding, 2);
    adv(); src_valid = 3'b101; src_data[15:0] = 16'h3C3C; smp();
    chk("t3_rdy_src0", src_ready, 3'b001);
    adv(); src_valid = 3'b100; smp();
    frame_chk("t3c", 0, 16'h3C3C);
    chk("t3_blk_c", src_ready, 0);
    adv(); rsp_done = 1'b1; smp();
    chk("t3_rsp_same", src_ready, 0);
    chk("t3_out_pre", outstanding, 2);
    adv(); rsp_done = 1'b0; smp();
    chk("t3_out_dec", outstanding, 1);
    chk("t3_unblk", src_ready, 3'b100);
    adv(); src_valid = 3'b000; smp();
    chk("t3_out_re", outstanding, 2);
    for (int k = 0; k < 9; k++) adv();
    adv(); smp();
    chk("t3_end_tx", tx_pins, 0);

    // Simultaneous grant and response; response with nothing outstanding
    adv(); rsp_done = 1'b1; smp();
    adv(); rsp_done = 1'b0; smp();
    chk("t4_out1", outstanding, 1);
    adv(); src_valid = 3'b100; rsp_done = 1'b1; smp();
    chk("t4_rdy", src_ready, 3'b100);
    adv(); src_valid = 3'b000; rsp_done = 1'b0; smp();
    chk("t4_same", outstanding, 1);
    for (int k = 0; k < 9; k++) adv();
    adv(); rsp_done = 1'b1; smp();
    adv(); rsp_done = 1'b0; smp();
    chk("t4_out0", outstanding, 0);
    chk("t4_cerr0", credit_err, 0);
    adv(); rsp_done = 1'b1; smp();
    adv(); rsp_done = 1'b0; smp();
    chk("t4_cerr1", credit_err, 1);
    chk("t4_sat", outstanding, 0);
    adv(); adv(); smp();
    chk("t4_sticky", credit_err, 1);

    // Reset in the middle of a payload
    adv(); src_valid = 3'b100; src_data[47:32] = 16'h5A5A; smp();
    chk("t5_rdy", src_ready, 3'b100);
    adv(); src_valid = 3'b000; smp();
    chk("t5_out1", outstanding, 1);
    adv(); adv(); adv(); adv(); reset = 1'b1; smp();
    chk("t5_pl2", tx_pins, 1);
    chk("t5_rst_rdy", src_ready, 0);
    adv(); reset = 1'b0; smp();
    chk("t5_tx0", tx_pins, 0);
    chk("t5_busy0", busy, 0);
    chk("t5_out0", outstanding, 0);
    chk("t5_cerr0", credit_err, 0);
    adv(); smp();
    chk("t5_tx0b", tx_pins, 0);
    adv(); src_valid = 3'b010; src_data[31:16] = 16'h0F0F; smp();
    chk("t5_rdy2", src_ready, 3'b010);
    adv(); src_valid = 3'b000; smp();
    frame_chk("t5f", 1, 16'h0F0F);
    adv(); smp();
    chk("t5_end_tx", tx_pins, 0);

    // Random traffic with an independent decoder and credit model
    adv(); reset = 1'b1; smp();
    adv(); reset = 1'b0; smp();
    model_out = 0;
    rdy = '0;
    for (int c = 0; c < 10000; c++) begin
      adv();
      for (int i = 0; i < 3; i++) begin
        if (src_valid[i] && rdy[i]) begin
          src_valid[i] = 1'b0;
        end else if (!src_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            src_valid[i] = 1'b1;
            src_data[16*i +: 16] = 16'($urandom_range(0, 65535));
          end
        end else if ($urandom_range(0, 63) == 0) begin
          src_valid[i] = 1'b0;
        end
      end
      rsp_done = (model_out > 0) && ($urandom_range(0, 7) == 0);
      smp();
      rdy = src_ready;
      chk("rnd_out", outstanding, model_out);
      bad[0] = ($countones(rdy) > 1);
      bad[1] = |(rdy & ~src_valid);
      bad[2] = rdy[2] && (model_out == 2);
      chk("rnd_rdy", bad, 0);
      dec_step();
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) expq.push_back({2'(i), src_data[16*i +: 16]});
      end
      if (rdy[2] && !rsp_done) model_out++;
      else if (!rdy[2] && rsp_done) model_out--;
    end
    adv(); src_valid = '0; rsp_done = 1'b0; smp();
    dec_step();
    for (int k = 0; k < 12; k++) begin
      adv(); smp();
      dec_step();
    end
    chk("rnd_drain", expq.size(), 0);
    chk("rnd_dpos", dpos, 0);
    chk("rnd_cerr", credit_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sbio_tx_arbiter.md
Name: sbio_tx_arbiter

Overview:
- Multi-source transmitter for the sbio serial link.
- Arbitrates among NUM_SOURCES word producers and frames each granted word on tx_pins as: start cycle, header cycle (source id), then payload cycles, LSB-first.
- Tracks outstanding request/response transactions and blocks response-expecting sources when the limit is reached.
- Sits between the context/memory/output producers and the chip's tx pins; replaces the single-source, unlimited tx path.

Parameters:
- IO_BITS, 2, pins per cycle; WORD_SIZE = PAYLOAD_CYCLES*IO_BITS.
- PAYLOAD_CYCLES, 8, payload cycles per message.
- NUM_SOURCES, 3, number of sources; must be <= 2**IO_BITS.
- START_BITS, 1, value driven in the start cycle; must be nonzero.
- RESPONSE_MASK, 3'b100, bit i set means source i expects a response.
- MAX_OUTSTANDING, 2, maximum unanswered transactions (>= 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- src_valid  in  NUM_SOURCES  request per source; held until granted
- src_data  in  NUM_SOURCES*WORD_SIZE  word i at [i*WORD_SIZE +: WORD_SIZE]
- src_ready  out  NUM_SOURCES  one-hot grant pulse; src_data is captured that cycle
- rsp_done  in  1  one-cycle pulse per received response
- tx_pins  out  IO_BITS  registered link output; 0 when idle
- busy  out  1  high during start, header and payload cycles
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current unanswered count
- credit_err  out  1  sticky; set by rsp_done when outstanding == 0

Behaviour:
- Reset values: tx_pins=0, busy=0, src_ready=0, outstanding=0, credit_err=0; internal state IDLE. Reset mid-message aborts the message: pins are 0 the next cycle and no src_ready is issued.
- FSM: IDLE -> START -> HEADER -> PAYLOAD(counter 0..PAYLOAD_CYCLES-1) -> START or IDLE.
- Eligible source: src_valid[i] && !(RESPONSE_MASK[i] && outstanding == MAX_OUTSTANDING).
- Grant occurs in any IDLE cycle, or in the last PAYLOAD cycle, when at least one source is eligible.
- Arbitration is fixed priority: lowest index wins. Grant is combinational from registered state.
- Grant at cycle T:
  - src_ready[i]=1 at T; word latched into the shift register at T.
  - T+1: tx_pins = START_BITS.
  - T+2: tx_pins = i (header).
  - T+3 .. T+2+PAYLOAD_CYCLES: payload, IO_BITS per cycle, LSB-first.
- Back-to-back messages have no idle gap. Message length is PAYLOAD_CYCLES+2 cycles.
- In the last PAYLOAD cycle with no grant, return to IDLE; tx_pins=0 the next cycle.
- Granting a RESPONSE_MASK source increments outstanding at the grant edge.
- rsp_done decrements outstanding. Grant and rsp_done in the same cycle leave it unchanged.
- rsp_done with outstanding==0: count stays 0 (saturates) and credit_err is set. Only reset clears credit_err.
- Grant eligibility uses the pre-update outstanding value, so a rsp_done arriving in the same cycle does not unblock that cycle.
- src_valid deasserted before grant: the request is withdrawn with no side effect.
- src_data changing after grant has no effect on the message in flight.
- An internal sbio_monitor instance (SENS_BITS=IO_BITS) on tx_pins cross-checks framing. Under simulation, assert that its counter matches the FSM every cycle.

Optional Feature:
- Macro SBIO_TX_RR_ARB_EN.
- Defined: round-robin arbitration. A last-grant pointer is updated on each grant, and search starts at the index after the last grant. The pointer resets to NUM_SOURCES-1, so source 0 has first priority.
- Undefined: fixed priority as described above. No pointer register is present.

Decomposition:
- Package sbio_pkg holds:
  - header codes (TX_SOURCE_SCAN=0, TX_SOURCE_READ, TX_SOURCE_OUT);
  - start-bit constants;
  - sbio_tx_state_e enum (IDLE, START, HEADER, PAYLOAD);
  - the WORD_SIZE / counter-width helper function.
- Sub-module sbio_prio_arbiter: takes the eligible vector and last pointer, outputs a one-hot grant. It contains the round-robin logic under the macro.

Test Plan (IO_BITS=2, PAYLOAD_CYCLES=8, NUM_SOURCES=3, MAX_OUTSTANDING=2):
- Single send: src1 raises valid with data 16'hA5C3 while idle -> src_ready[1] at T; tx_pins = 1, 1, then 3,0,0,3,1,1,2,2 over T+1..T+10; busy high T+1..T+10; tx_pins=0 at T+11.
- Contention: src0 and src1 valid together -> src0 granted first; src1 granted in src0's last payload cycle; src1's start cycle immediately follows with no zero gap. With SBIO_TX_RR_ARB_EN, src0 then src1 alternate while both stay valid.
- Credit limit: src2 held valid with rsp_done low -> exactly 2 messages, outstanding=2, then src2 blocked while src0 still gets granted. One rsp_done pulse -> src2 granted again at the next grant opportunity.
- Simultaneous events: rsp_done in src2's grant cycle with outstanding=1 -> outstanding stays 1. rsp_done with outstanding=0 -> credit_err=1, outstanding stays 0.
- Reset mid-payload (cycle T+5) -> tx_pins=0, busy=0, outstanding=0 next cycle; a fresh request afterwards frames correctly.
- Random valid/rsp_done over 10k cycles -> sbio_monitor framing never violated; outstanding never exceeds 2; every granted word reappears on tx_pins exactly once.
